matrix_multiplier: RTL and testbench

- Fixed-size unsigned 3x3 matrix multiplier: result = matrix_a × matrix_b.
- All nine dot products are computed in parallel in a two-stage pipeline.
- Operands are captured on a start strobe; the result is held in output registers until the next computation completes.
- Used as the arithmetic core feeding convolution and filter blocks.

---
 rtl/matrix_multiplier_pkg.sv | 21 ++
 rtl/matrix_multiplier_if.sv | 24 ++
 rtl/matrix_multiplier_dot_product3.sv | 51 +++++
 rtl/matrix_multiplier.sv | 54 +++++
 tb/tb_matrix_multiplier.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/matrix_multiplier_pkg.sv
// Shared sizing, element types and matrix types for the 3x3 matrix multiplier.
package matrix_mult_pkg;

  localparam int N      = 3;
  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  // Full-width dot-product accumulator: 2*DATA_W product bits plus two carry bits.
  localparam int SUM_W  = 2 * DATA_W + 2;

  typedef logic [DATA_W-1:0]   elem_t;
  typedef logic [RES_W-1:0]    res_t;
  typedef logic [2*DATA_W-1:0] prod_t;
  typedef logic [SUM_W-1:0]    sum_t;

  // One row of A or one column of B.
  typedef elem_t [N-1:0]         vec_t;
  // Matrices are indexed [row][col].
  typedef elem_t [N-1:0][N-1:0]  mat_in_t;
  typedef res_t  [N-1:0][N-1:0]  mat_res_t;

endpackage

// File: rtl/matrix_multiplier_if.sv
// Operand/result bundle of the matrix multiplier; the master launches, the slave computes.
interface matrix_multiplier_if;
  import matrix_mult_pkg::*;

  logic     start;
  mat_in_t  matrix_a;
  mat_in_t  matrix_b;
  mat_res_t result;

  modport master (
    output start,
    output matrix_a,
    output matrix_b,
    input  result
  );

  modport slave (
    input  start,
    input  matrix_a,
    input  matrix_b,
    output result
  );

endinterface

// File: rtl/matrix_multiplier_dot_product3.sv
// One output element of the product: registered products (stage 1), then a
// full-width sum truncated into a registered result (stage 2).
module dot_product3
  import matrix_mult_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic valid1,
  input  vec_t row_a,
  input  vec_t col_b,
  output res_t result
);

  prod_t prod_r [N];
  sum_t  sum_s;
  res_t  result_r;

  // Stage 1: capture the N element products whenever a computation is launched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        prod_r[k] <= '0;
      end
    end else if (load) begin
      for (int k = 0; k < N; k++) begin
        prod_r[k] <= prod_t'(row_a[k]) * prod_t'(col_b[k]);
      end
    end
  end

  // Accumulate the registered products at full width so no carry is lost before truncation.
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < N; k++) begin
      sum_s = sum_s + sum_t'(prod_r[k]);
    end
  end

  // Stage 2: publish the sum modulo 2^RES_W when stage 1 holds fresh products; otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_r <= '0;
    end else if (valid1) begin
      result_r <= res_t'(sum_s);
    end
  end

  assign result = result_r;

endmodule

// File: rtl/matrix_multiplier.sv
// Unsigned 3x3 matrix multiplier, two-stage pipeline, result = matrix_a x matrix_b.
module matrix_multiplier
  import matrix_mult_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  matrix_multiplier_if.slave  mm
);

  logic valid1_r;
  vec_t col_b_s [N];
  res_t elem_s  [N][N];

  // Track which edges loaded fresh products so stage 2 only updates on those.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid1_r <= 1'b0;
    end else begin
      valid1_r <= mm.start;
    end
  end

  // Transpose B into columns and build the N x N grid of dot-product cells.
  for (genvar j = 0; j < N; j++) begin : g_col
    for (genvar k = 0; k < N; k++) begin : g_gather
      assign col_b_s[j][k] = mm.matrix_b[k][j];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_elem
      dot_product3 u_dot (
        .clk    (clk),
        .reset  (reset),
        .load   (mm.start),
        .valid1 (valid1_r),
        .row_a  (mm.matrix_a[i]),
        .col_b  (col_b_s[j]),
        .result (elem_s[i][j])
      );
    end
  end

  // Pack the registered element outputs onto the result matrix.
  always_comb begin
    mm.result = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        mm.result[i][j] = elem_s[i][j];
      end
    end
  end

endmodule

// File: tb/tb_matrix_multiplier.sv
// Directed self-checking bench for matrix_multiplier with hand-computed products.
module tb_matrix_multiplier;
  import matrix_mult_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  matrix_multiplier_if mm_if ();

  matrix_multiplier dut (
    .clk   (clk),
    .reset (reset),
    .mm    (mm_if.slave)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic mat_in_t mk_in(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
    int      v [9];
    mat_in_t m;
    v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        m[i][j] = elem_t'(v[i*3+j]);
    return m;
  endfunction

  function automatic mat_res_t mk_res(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
    int       v [9];
    mat_res_t m;
    v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        m[i][j] = res_t'(v[i*3+j]);
    return m;
  endfunction

  task automatic check_mat(input string tag, input mat_res_t obs, input mat_res_t exp_m);
    n_vec++;
    if (obs !== exp_m) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_m);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  mat_res_t zero_m;
  mat_in_t  m_seq;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    zero_m = mk_res(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_seq  = mk_in(1, 2, 3, 4, 5, 6, 7, 8, 9);

    // Reset with arbitrary inputs and start high.
    reset = 1'b1;
    mm_if.start    = 1'b1;
    mm_if.matrix_a = mk_in(255, 17, 3, 9, 200, 44, 1, 2, 77);
    mm_if.matrix_b = mk_in(5, 6, 7, 8, 9, 10, 11, 12, 13);
    @(negedge clk);
    tick();
    check_mat("reset", mm_if.result, zero_m);
    reset = 1'b0;
    mm_if.start = 1'b0;
    tick(); tick(); tick();
    check_mat("reset_release", mm_if.result, zero_m);

    // General product, one start pulse.
    mm_if.matrix_a = m_seq;
    mm_if.matrix_b = mk_in(9, 8, 7, 6, 5, 4, 3, 2, 1);
    mm_if.start = 1'b1;
    tick();
    mm_if.start = 1'b0;
    check_mat("gen_latency", mm_if.result, zero_m);
    tick();
    check_mat("gen", mm_if.result, mk_res(30, 24, 18, 84, 69, 54, 138, 114, 90));
    tick(); tick();
    check_mat("gen_hold", mm_if.result, mk_res(30, 24, 18, 84, 69, 54, 138, 114, 90));
    mm_if.matrix_a = 'x;
    mm_if.matrix_b = 'x;
    tick(); tick();
    check_mat("x_hold", mm_if.result, mk_res(30, 24, 18, 84, 69, 54, 138, 114, 90));

    // Identity then 2I with start held high, inputs changed every 2 cycles.
    mm_if.start = 1'b1;
    mm_if.matrix_a = mk_in(1, 0, 0, 0, 1, 0, 0, 0, 1);
    mm_if.matrix_b = m_seq;
    tick(); tick();
    check_mat("identity", mm_if.result, mk_res(1, 2, 3, 4, 5, 6, 7, 8, 9));
    mm_if.matrix_a = mk_in(2, 0, 0, 0, 2, 0, 0, 0, 2);
    tick();
    check_mat("scale_pipe", mm_if.result, mk_res(1, 2, 3, 4, 5, 6, 7, 8, 9));
    tick();
    check_mat("scale", mm_if.result, mk_res(2, 4, 6, 8, 10, 12, 14, 16, 18));

    // Triangular operands.
    mm_if.matrix_a = mk_in(1, 2, 3, 0, 1, 4, 0, 0, 1);
    mm_if.matrix_b = mk_in(1, 0, 0, 2, 1, 0, 3, 4, 1);
    tick();
    mm_if.start = 1'b0;
    tick();
    check_mat("triangular", mm_if.result, mk_res(14, 14, 3, 14, 17, 4, 3, 4, 1));

    // Back-to-back starts, second one overflowing every element.
    mm_if.start = 1'b1;
    mm_if.matrix_a = mk_in(1, 1, 1, 1, 1, 1, 1, 1, 1);
    mm_if.matrix_b = mk_in(2, 2, 2, 2, 2, 2, 2, 2, 2);
    tick();
    mm_if.matrix_a = mk_in(255, 255, 255, 255, 255, 255, 255, 255, 255);
    mm_if.matrix_b = mk_in(255, 255, 255, 255, 255, 255, 255, 255, 255);
    tick();
    mm_if.start = 1'b0;
    check_mat("b2b_first", mm_if.result, mk_res(6, 6, 6, 6, 6, 6, 6, 6, 6));
    tick();
    check_mat("b2b_overflow", mm_if.result,
              mk_res(64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003));

    // Reset between launch edge and result edge.
    mm_if.start = 1'b1;
    mm_if.matrix_a = mk_in(1, 0, 0, 0, 1, 0, 0, 0, 1);
    mm_if.matrix_b = m_seq;
    tick();
    mm_if.start = 1'b0;
    #1 reset = 1'b1;
    #1 check_mat("midrst_now", mm_if.result, zero_m);
    #1 reset = 1'b0;
    tick();
    check_mat("midrst_edge", mm_if.result, zero_m);
    tick();
    check_mat("midrst_late", mm_if.result, zero_m);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
